// File: rtl/mandelbrot_iter_ctrl_if.sv
// Job handshake bundle for mandelbrot_iter_ctrl.
// master: the side that submits points and consumes results.
// slave : the iteration controller.
interface mandelbrot_iter_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_cr;
  logic signed [WIDTH-1:0]     in_ci;
  logic        [CNT_WIDTH-1:0] in_max_iter;
  logic                        out_valid;
  logic                        out_ready;
  logic        [CNT_WIDTH-1:0] out_iter;
  logic                        out_escaped;

  modport master (
    output in_valid, in_cr, in_ci, in_max_iter, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped
  );

  modport slave (
    input  in_valid, in_cr, in_ci, in_max_iter, out_ready,
    output in_ready, out_valid, out_iter, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl: sequences one point c through an external
// mandelbrot_alu (z <= z^2 + c) until the ALU flags an escape or the
// iteration limit N is reached. One job in flight at a time.
// Optional build macro MANDEL_CYCLE_DETECT_EN adds Brent-style cycle
// detection: a reference z is snapshotted at iter 0 and every power of two,
// and a repeat of that value ends the job early as "bounded".
module mandelbrot_iter_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mandelbrot_iter_ctrl_if.slave   job,
  output logic signed [WIDTH-1:0] alu_cr,
  output logic signed [WIDTH-1:0] alu_ci,
  output logic signed [WIDTH-1:0] alu_zr,
  output logic signed [WIDTH-1:0] alu_zi,
  input  logic signed [WIDTH-1:0] alu_out_zr,
  input  logic signed [WIDTH-1:0] alu_out_zi,
  input  logic                    alu_size,
  input  logic                    alu_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic signed [WIDTH-1:0] cr_reg, ci_reg, zr_reg, zi_reg;
  logic [CNT_WIDTH-1:0]  iter_reg;
  logic [CNT_WIDTH-1:0]  max_iter_reg;
  logic [CNT_WIDTH-1:0]  out_iter_reg;
  logic                  out_escaped_reg;
  logic [CNT_WIDTH-1:0]  iter_inc;

  // Per-cycle actions decoded by the FSM; at most one is set per cycle.
  logic accept;
  logic exit_esc;
  logic exit_lim;
  logic step;
  logic cycle_hit;

  // iter never exceeds N-1 in RUN, so iter+1 cannot wrap.
  assign iter_inc = iter_reg + CNT_WIDTH'(1);

`ifdef MANDEL_CYCLE_DETECT_EN
  logic [2*WIDTH-1:0] z_ref_reg;
  logic [2*WIDTH-1:0] z_cur;
  logic [2*WIDTH-1:0] z_cmp;
  logic               iter_pow2;

  // iter & (iter-1) is zero exactly when iter is zero or a power of two.
  assign iter_pow2 = ((iter_reg & (iter_reg - CNT_WIDTH'(1))) == '0);
  assign z_cur     = {zr_reg, zi_reg};
  assign z_cmp     = iter_pow2 ? z_cur : z_ref_reg;
  assign cycle_hit = ({alu_out_zr, alu_out_zi} == z_cmp);

  // Reference snapshot taken on the same cycles the live z is used as ref.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_ref_reg <= '0;
    end else if (state_reg == RUN && iter_pow2) begin
      z_ref_reg <= z_cur;
    end
  end
`else
  assign cycle_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and action decode: escape > cycle repeat > limit > step.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    exit_esc   = 1'b0;
    exit_lim   = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (job.in_valid) begin
          accept     = 1'b1;
          state_next = (job.in_max_iter == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (alu_size || alu_overflow) begin
          exit_esc   = 1'b1;
          state_next = DONE;
        end else if (cycle_hit || (iter_inc == max_iter_reg)) begin
          exit_lim   = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (job.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Job datapath: point, limit, running z/iter and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_reg          <= '0;
      ci_reg          <= '0;
      zr_reg          <= '0;
      zi_reg          <= '0;
      iter_reg        <= '0;
      max_iter_reg    <= '0;
      out_iter_reg    <= '0;
      out_escaped_reg <= 1'b0;
    end else begin
      if (accept) begin
        cr_reg          <= job.in_cr;
        ci_reg          <= job.in_ci;
        max_iter_reg    <= job.in_max_iter;
        zr_reg          <= '0;
        zi_reg          <= '0;
        iter_reg        <= '0;
        out_iter_reg    <= '0;
        out_escaped_reg <= 1'b0;
      end
      if (exit_esc) begin
        out_iter_reg    <= iter_reg;
        out_escaped_reg <= 1'b1;
      end
      if (exit_lim) begin
        out_iter_reg    <= max_iter_reg;
        out_escaped_reg <= 1'b0;
      end
      if (step) begin
        zr_reg   <= alu_out_zr;
        zi_reg   <= alu_out_zi;
        iter_reg <= iter_inc;
      end
    end
  end

  assign alu_cr = cr_reg;
  assign alu_ci = ci_reg;
  assign alu_zr = zr_reg;
  assign alu_zi = zi_reg;

  assign job.in_ready    = (state_reg == IDLE);
  assign job.out_valid   = (state_reg == DONE);
  assign job.out_iter    = out_iter_reg;
  assign job.out_escaped = out_escaped_reg;

endmodule
